// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  // Opcodes handled by this controller
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, in every state
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU control decode from ALUOp and the instruction function fields.
module alu_decoder
  import rv_mc_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [2:0] fun3,
  input  logic       op5,
  input  logic       fun75,
  output logic [2:0] alu_control
);

  // Only register-register forms with Instr[30] set select subtract;
  // addi ignores Instr[30] because it is immediate data there.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (fun3)
          3'b000:  alu_control = (op5 & fun75) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Control FSM sequencing a shared-memory multi-cycle RV32I datapath.
module multi_cycle_controller
  import rv_mc_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] Op,
  input  logic [2:0] fun3,
  input  logic       fun75,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Retire,
  output logic       Illegal
);

  state_t     state, state_next;
  aluop_t     alu_op;
  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_ctl;

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge Clk) begin
    if (Reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  // Per-state strobes, mux selects and next-state decode
  always_comb begin
    state_next = FETCH;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    case (state)
      FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (MemReady) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        // ALU precomputes OldPC + imm as a speculative branch target
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            illegal    = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_IMM;
        state_next = Op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        state_next = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = RES_READDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        // Write strobe stays up across wait states until memory accepts it
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (MemReady) begin
          retire     = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = MEMWRITE;
        end
      end
      EXECR: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_RD2;
        alu_op     = ALUOP_FUNC;
        state_next = ALUWB;
      end
      EXECI: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_IMM;
        alu_op     = ALUOP_FUNC;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        // PC takes the target held in ALUOut; ALU forms OldPC + 4 for rd
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .fun3        (fun3),
    .op5         (Op[5]),
    .fun75       (fun75),
    .alu_control (alu_ctl)
  );

  // Reset silences every output so no write fires on an abandoned instruction
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 2'b00;
    RegWrite   = 1'b0;
    Retire     = 1'b0;
    Illegal    = 1'b0;
    if (!Reset) begin
      PCWrite    = pc_update | (branch & Zero);
      AdrSrc     = adr_src;
      MemWrite   = mem_write;
      IRWrite    = ir_write;
      ResultSrc  = result_src;
      ALUSrcA    = src_a;
      ALUSrcB    = src_b;
      ALUControl = alu_ctl;
      ImmSrc     = imm_src_of(Op);
      RegWrite   = reg_write;
      Retire     = retire;
      Illegal    = illegal;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: reset, table of instructions, random stream.
module tb_multi_cycle_controller;

  logic       Clk = 1'b0, Reset = 1'b1;
  logic [6:0] Op = '0;
  logic [2:0] fun3 = '0;
  logic       fun75 = 1'b0, Zero = 1'b0, MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multi_cycle_controller dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .fun3(fun3), .fun75(fun75), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Retire(Retire),
    .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw, ret, ill;
  } out_t;

  out_t act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, Retire, Illegal};

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Instruction classes used by the model
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

  // Run one instruction from its FETCH to its Retire cycle, gathering statistics
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic z, input logic [31:0] mask,
                           output int cyc, output logic [2:0] alu2, output logic [1:0] imm0,
                           output int pcw, output int rw, output int mw, output int ill,
                           output int adr);
    logic done;
    cyc = 0; alu2 = 3'b111; imm0 = 2'b00; pcw = 0; rw = 0; mw = 0; ill = 0; adr = 0;
    done = 1'b0;
    Op = op; fun3 = f3; fun75 = f75; Zero = z;
    for (int c = 0; c < 24; c++) begin
      MemReady = ~mask[c];
      #1;
      cyc = c + 1;
      if (c == 0) imm0 = ImmSrc;
      if (c == 2) alu2 = ALUControl;
      pcw += int'(PCWrite); rw += int'(RegWrite); mw += int'(MemWrite);
      ill += int'(Illegal); adr += int'(AdrSrc);
      done = Retire;
      tick();
      if (done) break;
    end
    MemReady = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75, z;
    logic [31:0] mask;
    int          cyc;
    logic [2:0]  alu2;
    logic [1:0]  imm;
    int          pcw, rw, mw, ill, adr;
  } vec_t;

  // Expected cycle-by-cycle outputs for the random stream
  typedef struct { logic mr, z; out_t exp; } cyc_t;
  cyc_t q[$];

  function automatic logic [2:0] alu_exp(input int cls, input logic [2:0] f3, input logic f75);
    case (f3)
      3'b000:  return (cls == C_R && f75) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic mr, input logic z, input out_t o);
    cyc_t r;
    r.mr = mr; r.z = z; r.exp = o;
    q.push_back(r);
  endtask

  // Expand one instruction into its expected cycle list
  task automatic model(input int cls, input logic [2:0] f3, input logic f75,
                       input int fst, input int mst);
    out_t o;
    logic [1:0] imm;
    logic z;
    imm = (cls == C_SW) ? 2'b01 : (cls == C_BEQ) ? 2'b10 : (cls == C_JAL) ? 2'b11 : 2'b00;
    for (int i = 0; i <= fst; i++) begin
      o = '0; o.sb = 2'b10; o.rs = 2'b10; o.imm = imm;
      if (i == fst) begin o.irw = 1'b1; o.pcw = 1'b1; end
      push(i == fst, 1'($urandom_range(0, 1)), o);
    end
    o = '0; o.sa = 2'b01; o.sb = 2'b01; o.imm = imm;
    if (cls == C_ILL) begin o.ill = 1'b1; o.ret = 1'b1; end
    push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
    if (cls == C_ILL) return;
    case (cls)
      C_R, C_I, C_JAL: begin
        o = '0; o.imm = imm;
        if (cls == C_JAL) begin o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1; end
        else begin o.sa = 2'b10; o.sb = (cls == C_R) ? 2'b00 : 2'b01; o.alu = alu_exp(cls, f3, f75); end
        push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
        o = '0; o.imm = imm; o.rw = 1'b1; o.ret = 1'b1;
        push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
      end
      C_LW, C_SW: begin
        o = '0; o.imm = imm; o.sa = 2'b10; o.sb = 2'b01;
        push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
        for (int i = 0; i <= mst; i++) begin
          o = '0; o.imm = imm; o.adr = 1'b1; o.mw = (cls == C_SW);
          if (cls == C_SW && i == mst) o.ret = 1'b1;
          push(i == mst, 1'($urandom_range(0, 1)), o);
        end
        if (cls == C_LW) begin
          o = '0; o.imm = imm; o.rs = 2'b01; o.rw = 1'b1; o.ret = 1'b1;
          push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
        end
      end
      default: begin // C_BEQ
        z = 1'($urandom_range(0, 1));
        o = '0; o.imm = imm; o.sa = 2'b10; o.sb = 2'b00; o.alu = 3'b001; o.ret = 1'b1; o.pcw = z;
        push(1'($urandom_range(0, 1)), z, o);
      end
    endcase
  endtask

  initial begin
    vec_t tbl[15];
    int cyc, pcw, rw, mw, ill, adr;
    logic [2:0] alu2;
    logic [1:0] imm0;
    logic [6:0] ops[7];
    logic [6:0] ill_ops[3];
    logic [2:0] f3s[6];
    cyc_t r;

    //        name       op          f3      f75  z    mask   cyc alu2    imm   pcw rw mw ill adr
    tbl[0]  = '{"sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 32'h0,  4, 3'b001, 2'b00, 1, 1, 0, 0, 0};
    tbl[1]  = '{"add",   7'b0110011, 3'b000, 1'b0, 1'b0, 32'h0,  4, 3'b000, 2'b00, 1, 1, 0, 0, 0};
    tbl[2]  = '{"slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 32'h0,  4, 3'b101, 2'b00, 1, 1, 0, 0, 0};
    tbl[3]  = '{"or",    7'b0110011, 3'b110, 1'b0, 1'b0, 32'h0,  4, 3'b011, 2'b00, 1, 1, 0, 0, 0};
    tbl[4]  = '{"and",   7'b0110011, 3'b111, 1'b1, 1'b0, 32'h0,  4, 3'b010, 2'b00, 1, 1, 0, 0, 0};
    tbl[5]  = '{"sll",   7'b0110011, 3'b001, 1'b0, 1'b0, 32'h0,  4, 3'b000, 2'b00, 1, 1, 0, 0, 0};
    tbl[6]  = '{"addi30",7'b0010011, 3'b000, 1'b1, 1'b0, 32'h0,  4, 3'b000, 2'b00, 1, 1, 0, 0, 0};
    tbl[7]  = '{"slti",  7'b0010011, 3'b010, 1'b0, 1'b0, 32'h0,  4, 3'b101, 2'b00, 1, 1, 0, 0, 0};
    tbl[8]  = '{"lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 32'h0,  5, 3'b000, 2'b00, 1, 1, 0, 0, 1};
    tbl[9]  = '{"lwwait",7'b0000011, 3'b010, 1'b0, 1'b0, 32'h38, 8, 3'b000, 2'b00, 1, 1, 0, 0, 4};
    tbl[10] = '{"sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 32'h0,  4, 3'b000, 2'b01, 1, 0, 1, 0, 1};
    tbl[11] = '{"beqz1", 7'b1100011, 3'b000, 1'b0, 1'b1, 32'h0,  3, 3'b001, 2'b10, 2, 0, 0, 0, 0};
    tbl[12] = '{"beqz0", 7'b1100011, 3'b000, 1'b0, 1'b0, 32'h0,  3, 3'b001, 2'b10, 1, 0, 0, 0, 0};
    tbl[13] = '{"jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 32'h0,  4, 3'b000, 2'b11, 2, 1, 0, 0, 0};
    tbl[14] = '{"illeg", 7'b1111111, 3'b000, 1'b0, 1'b0, 32'h0,  2, 3'b111, 2'b00, 1, 0, 0, 1, 0};

    // Reset held: all outputs quiet
    tick(); tick();
    #1 check("reset_quiet", act, 18'h0);
    tick();
    Reset = 1'b0; Op = 7'b0110011; MemReady = 1'b1;
    #1 check("first_fetch", act, {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000});
    tick();
    Reset = 1'b1; tick(); Reset = 1'b0;

    // Reset asserted for 2 cycles while a store waits in MEMWRITE
    Op = 7'b0100011; MemReady = 1'b1;
    tick(); tick(); tick();          // FETCH, DECODE, MEMADR
    MemReady = 1'b0;
    #1 check("sw_wait_mw", 32'(MemWrite), 32'd1);
    Reset = 1'b1;
    #1 check("rst_mw_c1", act, 18'h0);
    tick();
    #1 check("rst_mw_c2", act, 18'h0);
    tick();
    Reset = 1'b0; MemReady = 1'b1;
    #1;
    check("post_rst_irw", 32'(IRWrite), 32'd1);
    check("post_rst_pcw", 32'(PCWrite), 32'd1);
    check("post_rst_srcb", 32'(ALUSrcB), 32'd2);
    check("post_rst_mw", 32'(MemWrite), 32'd0);
    tick();
    Reset = 1'b1; tick(); Reset = 1'b0;

    // Table-driven instruction runs
    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f75, tbl[i].z, tbl[i].mask,
                cyc, alu2, imm0, pcw, rw, mw, ill, adr);
      check({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].cyc));
      check({tbl[i].name, "_alu"}, 32'(alu2), 32'(tbl[i].alu2));
      check({tbl[i].name, "_imm"}, 32'(imm0), 32'(tbl[i].imm));
      check({tbl[i].name, "_pcw"}, 32'(pcw), 32'(tbl[i].pcw));
      check({tbl[i].name, "_rw"}, 32'(rw), 32'(tbl[i].rw));
      check({tbl[i].name, "_mw"}, 32'(mw), 32'(tbl[i].mw));
      check({tbl[i].name, "_ill"}, 32'(ill), 32'(tbl[i].ill));
      check({tbl[i].name, "_adr"}, 32'(adr), 32'(tbl[i].adr));
    end

    // Random instruction stream with random wait states
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1111111};
    ill_ops = '{7'b1111111, 7'b0110111, 7'b1100111};
    f3s = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b100};
    for (int n = 0; n < 80; n++) begin
      int cls, fst, mst;
      logic [2:0] f3;
      logic f75;
      cls = int'($urandom_range(0, 6));
      f3 = f3s[$urandom_range(0, 5)];
      f75 = 1'($urandom_range(0, 1));
      fst = int'($urandom_range(0, 2));
      mst = int'($urandom_range(0, 3));
      Op = (cls == C_ILL) ? ill_ops[$urandom_range(0, 2)] : ops[cls];
      fun3 = f3; fun75 = f75;
      q.delete();
      model(cls, f3, f75, fst, mst);
      while (q.size() > 0) begin
        r = q.pop_front();
        MemReady = r.mr; Zero = r.z;
        #1 check($sformatf("rand%0d_op%b", n, Op), act, r.exp);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
